cmp_ctrl: RTL
=============

# cmp_ctrl

Sequencer for the compare unit of the Harvard Architecture Processor. It accepts one compare instruction at a time over a valid/ready handshake. It then reads both source registers through a single register-file read port, presents opcode and operands to the combinational compare unit, and writes the 1-bit Yes/No result (zero-extended) back to the destination register. It also keeps a saturating count of Yes results for debug and performance observation.

## Interface
Parameters:
- DW, 3, register data width (matches compare operand/result width)
- AW, 3, register address width
- OW, 5, opcode width
- CW, 8, width of the Yes-result counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept an instruction
- instr_op  in  OW  compare opcode
- instr_rs1  in  AW  first source register address
- instr_rs2  in  AW  second source register address
- instr_rd  in  AW  destination register address
- rf_raddr  out  AW  register-file read address (combinational read)
- rf_rdata  in  DW  register-file read data, valid in the same cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  write address
- rf_wdata  out  DW  write data
- cmp_opcode  out  OW  opcode to compare unit
- cmp_r1  out  DW  operand 1 to compare unit
- cmp_r2  out  DW  operand 2 to compare unit
- cmp_rd  in  DW  compare unit result
- done  out  1  one-cycle pulse; instruction completed with writeback
- illegal  out  1  one-cycle pulse; instruction rejected (opcode not a compare)
- yes_count  out  CW  saturating count of Yes results written back
- cnt_clr  in  1  synchronous clear of yes_count

## Operation
- Legal opcodes: LT 01011, GT 01100, EQ 01101, GTE 01110, LTE 01111, NE 10000. All other opcodes are illegal.
- FSM states: IDLE, READ1, READ2, EXEC, WB, REJ.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch op/rs1/rs2/rd.
  - Next state is READ1 if op is legal, else REJ.
- READ1: rf_raddr=rs1; latch rf_rdata into opa at the clock edge; next state READ2.
- READ2: rf_raddr=rs2; latch rf_rdata into opb; next state EXEC.
- EXEC: cmp_opcode=op, cmp_r1=opa, cmp_r2=opb; latch cmp_rd into res; next state WB.
- WB:
  - rf_we=1, rf_waddr=rd, rf_wdata=res, done=1.
  - If res[0]=1 and yes_count is not all-ones, yes_count increments at the clock edge.
  - Next state IDLE.
- REJ: illegal=1, no register-file access, no count change; next state IDLE.
- Outside EXEC, cmp_opcode=00000 (compare unit returns No). cmp_r1/cmp_r2 show the held opa/opb.
- Outside READ1/READ2, rf_raddr holds rs1.
- Outside WB: rf_we=0, rf_waddr=rd, rf_wdata=res.
- instr_ready=0 in every state except IDLE. Offered instructions wait; the controller never drops them.
- Register hazards:
  - rs1==rs2 is legal and produces two identical reads.
  - rd equal to the next instruction's rs1 or rs2 needs no forwarding, because the write completes before the next read.
- yes_count:
  - Saturates at 2^CW−1.
  - cnt_clr sets it to 0 on the next edge.
  - If cnt_clr and an increment coincide, clear wins (result 0).

## Timing
- Reset (async, any state): state=IDLE.
  - All latches: op=00000; rs1, rs2, rd, opa, opb, res = 0.
  - Outputs: yes_count=0, rf_we=0, done=0, illegal=0, cmp_opcode=00000, instr_ready=1 (combinational from state IDLE).
  - A reset during READ1..WB aborts the instruction. No write occurs if reset asserts before the WB edge.
- Legal instruction accepted at edge E0: READ1 in cycle E0..E1, READ2 E1..E2, EXEC E2..E3, WB E3..E4.
  - The write commits at E4.
  - instr_ready returns high in cycle E4..E5.
  - Earliest next accept is E5; throughput is 1 instruction per 5 cycles.
- Illegal instruction accepted at E0: illegal high in cycle E0..E1; ready again from E1.
- done and illegal are never high together, and each lasts exactly one cycle.

## Test plan
- Reset then idle:
  - Assert reset mid-cycle.
  - Required: all outputs at reset values immediately; instr_ready=1, yes_count=0.
- LT, reg1=2, reg2=5, rd=7, accepted at E0:
  - READ1 at E0..E1, then READ2: rf_raddr=1 then 2.
  - cmp_opcode=01011 only in cycle E2..E3.
  - WB: rf_we=1, waddr=7, wdata=001 in cycle E3..E4; done pulse; yes_count=1.
- Back-to-back with instr_valid held high, EQ reg3=4 reg4=6 then NE same regs:
  - Second accept exactly at E5.
  - Results 000 then 001; yes_count +1 total.
- Illegal opcode 00101:
  - illegal pulse one cycle later; rf_we never asserts; yes_count unchanged.
  - Next legal instruction accepted one cycle after the pulse.
- Reset asserted during EXEC of GT 6>1:
  - No rf_we; state IDLE; yes_count=0.
  - A re-issued GT completes normally.
- Counter boundary:
  - Preload 255 Yes results: count stays 255 after a 256th Yes.
  - cnt_clr coincident with a WB Yes gives 0.

Source files
------------

// File: rtl/cmp_ctrl.sv
// Compare-instruction sequencer: accepts one instruction, reads both sources through a
// single register-file port, drives the compare unit, writes the 1-bit result back and
// keeps a saturating count of Yes results.
module cmp_ctrl #(
  parameter int unsigned DW = 3,
  parameter int unsigned AW = 3,
  parameter int unsigned OW = 5,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [OW-1:0] instr_op,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [AW-1:0] instr_rd,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [OW-1:0] cmp_opcode,
  output logic [DW-1:0] cmp_r1,
  output logic [DW-1:0] cmp_r2,
  input  logic [DW-1:0] cmp_rd,
  output logic          done,
  output logic          illegal,
  output logic [CW-1:0] yes_count,
  input  logic          cnt_clr
);

  localparam logic [OW-1:0] OpLt  = OW'(5'b01011);
  localparam logic [OW-1:0] OpGt  = OW'(5'b01100);
  localparam logic [OW-1:0] OpEq  = OW'(5'b01101);
  localparam logic [OW-1:0] OpGte = OW'(5'b01110);
  localparam logic [OW-1:0] OpLte = OW'(5'b01111);
  localparam logic [OW-1:0] OpNe  = OW'(5'b10000);

  typedef enum logic [2:0] {StIdle, StRead1, StRead2, StExec, StWb, StRej} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] op_q;
  logic [AW-1:0] rs1_q, rs2_q, rd_q;
  logic [DW-1:0] opa_q, opb_q, res_q;
  logic [CW-1:0] cnt_q;
  logic          instr_legal;
  logic          accept;

  // Decode whether the offered opcode is one of the compare operations.
  always_comb begin
    instr_legal = 1'b0;
    case (instr_op)
      OpLt, OpGt, OpEq, OpGte, OpLte, OpNe: instr_legal = 1'b1;
      default:                              instr_legal = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) && instr_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed walk through the read/execute/writeback sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = instr_legal ? StRead1 : StRej;
      StRead1: state_d = StRead2;
      StRead2: state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      StRej:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Instruction fields, operands, result and the Yes counter; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        rd_q  <= instr_rd;
      end
      if (state_q == StRead1) opa_q <= rf_rdata;
      if (state_q == StRead2) opb_q <= rf_rdata;
      if (state_q == StExec)  res_q <= cmp_rd;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if ((state_q == StWb) && res_q[0] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Outputs are decoded from state; held fields are shown whenever not in use.
  always_comb begin
    instr_ready = (state_q == StIdle);
    rf_raddr    = (state_q == StRead2) ? rs2_q : rs1_q;
    rf_we       = (state_q == StWb);
    rf_waddr    = rd_q;
    rf_wdata    = res_q;
    cmp_opcode  = (state_q == StExec) ? op_q : '0;
    cmp_r1      = opa_q;
    cmp_r2      = opb_q;
    done        = (state_q == StWb);
    illegal     = (state_q == StRej);
    yes_count   = cnt_q;
  end

endmodule
